load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU in the RV32I core.
- Takes the ALU result as the effective address and rs2 as store data.
- Drives a request/acknowledge data-memory bus and returns load data to the register-file write-back mux.
- Handles byte, halfword and word access: byte enables, lane replication, load sign/zero extension and alignment checks. Holds the core through `Stall` until each access completes.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in ACCESS without DM_Ack before a bus-error fault. Range 1..65535.

Ports:
- CLK  in  1  core clock; all state updates on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- MEM_Read  in  1  load instruction in decode (from control unit).
- MEM_Write  in  1  store instruction in decode.
- Funct3  in  3  instruction funct3 (access size/sign).
- ALU_Output  in  32  effective address from the ALU.
- READ_Data_2  in  32  store data (rs2).
- Stall  out  1  hold PC and suppress register write while high.
- Load_Data  out  32  extended load result.
- Done  out  1  one-cycle completion pulse.
- Fault  out  1  one-cycle fault pulse.
- Fault_Cause  out  2  valid with Fault: 01 misaligned, 10 timeout, 11 illegal funct3.
- DM_Req  out  1  memory request.
- DM_We  out  1  1 = write.
- DM_Addr  out  32  word-aligned address, ALU_Output with [1:0] forced to 00.
- DM_WData  out  32  lane-replicated store data.
- DM_BE  out  4  byte enables.
- DM_Ack  in  1  memory completion.
- DM_RData  in  32  read word, valid with DM_Ack.

Behaviour:
- Reset, asynchronous and immediate, including mid-access: state=IDLE; DM_Req, DM_We, Done, Fault=0; DM_Addr, DM_WData, Load_Data=0; DM_BE=0000; Fault_Cause=00; timeout counter=0.
- States: IDLE, ACCESS, DONE, ERR.
- IDLE, no request: nothing happens.
- IDLE, MEM_Read or MEM_Write high, evaluated on the clock edge. MEM_Write wins if both are high.
  - Illegal funct3 → ERR, cause 11. Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW.
  - Otherwise misaligned → ERR, cause 01. Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠00.
  - Otherwise → ACCESS. Register DM_Req=1, DM_We, DM_Addr, DM_BE, DM_WData, and latch addr[1:0] and funct3. Clear the counter.
- Byte enables and write data:
  - Loads: DM_BE=1111.
  - SB: DM_BE=0001<<addr[1:0], DM_WData = byte replicated ×4.
  - SH: DM_BE=0011<<addr[1:0], DM_WData = halfword replicated ×2.
  - SW: DM_BE=1111, DM_WData = rs2.
- ACCESS: DM_Req and all DM_* outputs held stable until exit.
  - DM_Ack=1 → DONE, DM_Req drops at that edge. On a load, Load_Data captures the selected lane of DM_RData, extended per the latched funct3 (LB/LH sign, LBU/LHU zero).
  - Otherwise the counter increments. When counter=TIMEOUT_CYCLES-1 and no Ack → ERR, cause 10, DM_Req drops.
  - Ack in the same cycle as the timeout → Ack wins.
- DONE: Done=1 for exactly one cycle, then → IDLE.
- ERR: Fault=1 and Fault_Cause valid for exactly one cycle, then → IDLE. No bus request is ever issued for cause 01 or 11.
- Stall is combinational: 1 when (IDLE and (MEM_Read or MEM_Write)) or ACCESS; 0 in DONE and ERR.
  - The core advances during DONE/ERR, so a request still visible in that cycle is not re-issued.
- Latency: request seen in cycle 0 → DM_Req from cycle 1. Ack in cycle k (k≥1) → Done in cycle k+1. Minimum 2 cycles of Stall.
- DM_Ack outside ACCESS is ignored.
- Load_Data holds its value until the next successful load. Stores and faults do not modify it.
- Back-to-back: a new request may be accepted in the IDLE cycle immediately after DONE/ERR.

Test Plan:
- LW, addr 0x0000_1004, Ack 3 cycles after Req, RData 0xDEAD_BEEF → DM_Addr 0x1004, BE 1111, Done in cycle 4, Load_Data 0xDEAD_BEEF, Stall high cycles 0–3.
- LB at 0x...03 with RData 0x80xx_xxxx → 0xFFFF_FF80; LBU same → 0x0000_0080; LH at 0x...02 with RData 0x8001_xxxx → 0xFFFF_8001.
- SB addr 0x...02, rs2 0x0000_00A5 → DM_We=1, BE 0100, WData 0xA5A5_A5A5. SH at 0x...02 → BE 1100. Load_Data unchanged.
- SW at 0x...02 → Fault, cause 01, DM_Req never asserted. Funct3=011 with MEM_Read → Fault, cause 11.
- TIMEOUT_CYCLES=4, no Ack → DM_Req high 4 cycles, Fault cause 10. Repeat with Ack on the 4th cycle → Done, no Fault.
- RSTN low mid-ACCESS → DM_Req=0 immediately, Stall=0; after release a new LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: byte/half/word loads and stores over a req/ack data bus, stalling the core until each access ends.
// Latency: request seen in cycle 0, DM_Req from cycle 1, Done one cycle after DM_Ack.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        MEM_Read,
  input  logic        MEM_Write,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALU_Output,
  input  logic [31:0] READ_Data_2,
  output logic        Stall,
  output logic [31:0] Load_Data,
  output logic        Done,
  output logic        Fault,
  output logic [1:0]  Fault_Cause,
  output logic        DM_Req,
  output logic        DM_We,
  output logic [31:0] DM_Addr,
  output logic [31:0] DM_WData,
  output logic [3:0]  DM_BE,
  input  logic        DM_Ack,
  input  logic [31:0] DM_RData
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] tmo_cnt;
  logic [1:0]  addr_lo_q;
  logic [2:0]  funct3_q;
  logic [1:0]  cause_q;

  logic        req_any;
  logic        f3_illegal;
  logic        misalign;
  logic        timeout_hit;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] lane_shift;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;

  assign req_any     = MEM_Read | MEM_Write;
  assign timeout_hit = (tmo_cnt == TMO_LAST);

  // Request decode; MEM_Write takes priority when both strobes are high.
  always_comb begin
    f3_illegal = 1'b0;
    misalign   = 1'b0;
    be_nxt     = 4'b1111;
    wdata_nxt  = READ_Data_2;
    if (MEM_Write) begin
      f3_illegal = (Funct3 != 3'b000) && (Funct3 != 3'b001) && (Funct3 != 3'b010);
    end else begin
      f3_illegal = (Funct3 == 3'b011) || (Funct3 == 3'b110) || (Funct3 == 3'b111);
    end
    case (Funct3[1:0])
      2'b01:   misalign = ALU_Output[0];
      2'b10:   misalign = (ALU_Output[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
    if (MEM_Write) begin
      case (Funct3[1:0])
        2'b00: begin
          be_nxt    = 4'b0001 << ALU_Output[1:0];
          wdata_nxt = {4{READ_Data_2[7:0]}};
        end
        2'b01: begin
          be_nxt    = 4'b0011 << ALU_Output[1:0];
          wdata_nxt = {2{READ_Data_2[15:0]}};
        end
        default: begin
          be_nxt    = 4'b1111;
          wdata_nxt = READ_Data_2;
        end
      endcase
    end
  end

  // Lane select and extension use the offset/funct3 latched at issue.
  always_comb begin
    lane_shift = DM_RData >> {addr_lo_q, 3'b000};
    lane_byte  = lane_shift[7:0];
    lane_half  = addr_lo_q[1] ? DM_RData[31:16] : DM_RData[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_ext = {24'h000000, lane_byte};
      3'b101:  load_ext = {16'h0000, lane_half};
      default: load_ext = DM_RData;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_any) begin
          state_nxt = (f3_illegal || misalign) ? ERR : ACCESS;
        end
      end
      ACCESS: begin
        if (DM_Ack) begin
          state_nxt = DONE;
        end else if (timeout_hit) begin
          state_nxt = ERR;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      DM_Req    <= 1'b0;
      DM_We     <= 1'b0;
      DM_Addr   <= 32'h0;
      DM_WData  <= 32'h0;
      DM_BE     <= 4'b0000;
      Load_Data <= 32'h0;
      tmo_cnt   <= 16'h0;
      addr_lo_q <= 2'b00;
      funct3_q  <= 3'b000;
      cause_q   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            if (f3_illegal) begin
              cause_q <= CAUSE_ILLEGAL;
            end else if (misalign) begin
              cause_q <= CAUSE_MISALIGN;
            end else begin
              DM_Req    <= 1'b1;
              DM_We     <= MEM_Write;
              DM_Addr   <= {ALU_Output[31:2], 2'b00};
              DM_BE     <= be_nxt;
              DM_WData  <= wdata_nxt;
              addr_lo_q <= ALU_Output[1:0];
              funct3_q  <= Funct3;
              tmo_cnt   <= 16'h0;
            end
          end
        end
        ACCESS: begin
          // Ack beats a coincident timeout.
          if (DM_Ack) begin
            DM_Req <= 1'b0;
            DM_We  <= 1'b0;
            if (!DM_We) begin
              Load_Data <= load_ext;
            end
          end else if (timeout_hit) begin
            DM_Req  <= 1'b0;
            DM_We   <= 1'b0;
            cause_q <= CAUSE_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Stall       = ((state == IDLE) && req_any) || (state == ACCESS);
  assign Done        = (state == DONE);
  assign Fault       = (state == ERR);
  assign Fault_Cause = (state == ERR) ? cause_q : 2'b00;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit against a size/offset arithmetic model.
module tb_load_store_unit;
  localparam int TMO = 4;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        MEM_Read, MEM_Write;
  logic [2:0]  Funct3;
  logic [31:0] ALU_Output, READ_Data_2;
  logic        Stall, Done, Fault;
  logic [31:0] Load_Data;
  logic [1:0]  Fault_Cause;
  logic        DM_Req, DM_We;
  logic [31:0] DM_Addr, DM_WData;
  logic [3:0]  DM_BE;
  logic        DM_Ack;
  logic [31:0] DM_RData;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RSTN(RSTN), .MEM_Read(MEM_Read), .MEM_Write(MEM_Write),
    .Funct3(Funct3), .ALU_Output(ALU_Output), .READ_Data_2(READ_Data_2),
    .Stall(Stall), .Load_Data(Load_Data), .Done(Done), .Fault(Fault),
    .Fault_Cause(Fault_Cause), .DM_Req(DM_Req), .DM_We(DM_We),
    .DM_Addr(DM_Addr), .DM_WData(DM_WData), .DM_BE(DM_BE),
    .DM_Ack(DM_Ack), .DM_RData(DM_RData)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit        fault;
    bit [1:0]  cause;
    bit [31:0] ld;
    int        reqc;
    int        lat;
    bit        we;
    bit [31:0] addr;
    bit [3:0]  be;
    bit [31:0] wdata;
  } exp_t;

  exp_t      exp_q[$];
  bit [31:0] model_ld = 32'h0;
  int        n_vec = 0;
  int        n_mis = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Reference model: derives the whole outcome of one request from the ISA rules.
  function automatic exp_t model(input bit rd, input bit wr, input bit [2:0] f3,
                                 input bit [31:0] addr, input bit [31:0] wd,
                                 input bit [31:0] rdata, input int ackj, input bit [31:0] ld_in);
    exp_t e;
    bit legal;
    int size, off;
    bit [31:0] v, mask;
    e = '{fault: 0, cause: 0, ld: ld_in, reqc: 0, lat: 1, we: wr,
          addr: addr & 32'hFFFF_FFFC, be: 4'hF, wdata: 0};
    if (wr) legal = (f3 <= 3'd2);
    else    legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    size = 1 << f3[1:0];
    off  = int'(addr % 4);
    if (!legal) begin
      e.fault = 1; e.cause = 2'b11;
    end else if (addr % size != 0) begin
      e.fault = 1; e.cause = 2'b01;
    end else begin
      if (wr) begin
        e.be = 4'(((1 << size) - 1) << off);
        if (size == 1)      e.wdata = wd[7:0] * 32'h0101_0101;
        else if (size == 2) e.wdata = wd[15:0] * 32'h0001_0001;
        else                e.wdata = wd;
      end
      if (ackj <= TMO) begin
        e.reqc = ackj;
        e.lat  = ackj + 1;
        if (!wr) begin
          mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 1);
          v = (rdata >> (8 * off)) & mask;
          if (size < 4 && !f3[2] && v[8 * size - 1]) v = v | ~mask;
          e.ld = v;
        end
      end else begin
        e.fault = 1; e.cause = 2'b10; e.reqc = TMO; e.lat = TMO + 1;
      end
    end
    return e;
  endfunction

  task automatic run_txn(input bit rd, input bit wr, input bit [2:0] f3, input bit [31:0] addr,
                         input bit [31:0] wd, input bit [31:0] rdata, input int ackj);
    exp_t e;
    int c = 0, stalls = 0, seen = 0;
    bit fin = 0;
    e = model(rd, wr, f3, addr, wd, rdata, ackj, model_ld);
    model_ld = e.ld;
    exp_q.push_back(e);
    @(negedge CLK);
    DM_Ack = 0;
    MEM_Read = rd; MEM_Write = wr; Funct3 = f3; ALU_Output = addr; READ_Data_2 = wd;
    while (!fin && c < 40) begin
      #1;
      if (Done || Fault) begin
        fin = 1;
        chk("stall_at_end", Stall, 1'b0);
        MEM_Read = 0; MEM_Write = 0;
      end else begin
        if (Stall) stalls++;
        if (DM_Req) begin
          seen++;
          if (seen == ackj) begin DM_Ack = 1; DM_RData = rdata; end
        end
        @(negedge CLK);
        DM_Ack = 0;
        DM_RData = $urandom;
        c++;
      end
    end
    if (!fin) begin
      chk("txn_hang", 32'(Done | Fault), 32'h1);
      MEM_Read = 0; MEM_Write = 0;
    end
    chk("latency", 32'(c), 32'(e.lat));
    chk("stall_cycles", 32'(stalls), 32'(e.lat));
  endtask

  // Monitor: checks bus fields while DM_Req is up and pops one expectation per Done/Fault.
  initial begin
    int rq = 0;
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (!RSTN) begin
        rq = 0;
      end else begin
        if (DM_Req) begin
          rq++;
          if (exp_q.size() == 0) chk("req_unexpected", 32'(DM_Req), 32'h0);
          else begin
            chk("dm_addr", DM_Addr, exp_q[0].addr);
            chk("dm_we", 32'(DM_We), 32'(exp_q[0].we));
            chk("dm_be", 32'(DM_BE), 32'(exp_q[0].be));
            if (exp_q[0].we) chk("dm_wdata", DM_WData, exp_q[0].wdata);
          end
        end
        if (Done || Fault) begin
          if (exp_q.size() == 0) chk("spurious_end", 32'(Done | Fault), 32'h0);
          else begin
            e = exp_q.pop_front();
            chk("fault", 32'(Fault), 32'(e.fault));
            chk("done", 32'(Done), 32'(!e.fault));
            chk("fault_cause", 32'(Fault_Cause), 32'(e.cause));
            chk("load_data", Load_Data, e.ld);
            chk("req_cycles", 32'(rq), 32'(e.reqc));
          end
          rq = 0;
        end
      end
    end
  end

  initial begin
    int guard;
    RSTN = 0; MEM_Read = 0; MEM_Write = 0; Funct3 = 0; ALU_Output = 0; READ_Data_2 = 0;
    DM_Ack = 0; DM_RData = 0;
    #1;
    chk("rst_req", 32'(DM_Req), 0);
    chk("rst_be", 32'(DM_BE), 0);
    chk("rst_addr", DM_Addr, 0);
    chk("rst_wdata", DM_WData, 0);
    chk("rst_ld", Load_Data, 0);
    chk("rst_flags", {29'h0, Done, Fault, Stall}, 0);
    chk("rst_cause", 32'(Fault_Cause), 0);
    repeat (2) @(negedge CLK);
    RSTN = 1;

    // Directed cases
    run_txn(1, 0, 3'b010, 32'h0000_1004, 32'h0,         32'hDEAD_BEEF, 3);
    run_txn(1, 0, 3'b000, 32'h0000_2003, 32'h0,         32'h8012_3456, 1);
    run_txn(1, 0, 3'b100, 32'h0000_2003, 32'h0,         32'h8012_3456, 2);
    run_txn(1, 0, 3'b001, 32'h0000_2002, 32'h0,         32'h8001_5678, 1);
    run_txn(0, 1, 3'b000, 32'h0000_3002, 32'h0000_00A5, 32'h0,         2);
    run_txn(0, 1, 3'b001, 32'h0000_3002, 32'h1234_BEEF, 32'h0,         1);
    run_txn(0, 1, 3'b010, 32'h0000_3002, 32'h1111_2222, 32'h0,         1);
    run_txn(1, 0, 3'b011, 32'h0000_4000, 32'h0,         32'h0,         1);
    run_txn(1, 0, 3'b010, 32'h0000_5000, 32'h0,         32'h0,         9);
    run_txn(1, 0, 3'b010, 32'h0000_5004, 32'h0,         32'hCAFE_F00D, 4);
    run_txn(1, 1, 3'b000, 32'h0000_6001, 32'h0000_0077, 32'h0,         2);
    run_txn(0, 1, 3'b100, 32'h0000_6000, 32'h0,         32'h0,         1);
    run_txn(1, 0, 3'b101, 32'h0000_7002, 32'h0,         32'hF00F_1234, 1);

    // Randomized traffic with idle gaps carrying stray acks
    for (int i = 0; i < 300; i++) begin
      int op;
      bit [31:0] a;
      op = $urandom_range(0, 2);
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_txn(op != 1, op != 0, 3'($urandom_range(0, 7)), a, $urandom, $urandom,
              $urandom_range(1, 6));
      repeat ($urandom_range(0, 2)) begin
        @(negedge CLK);
        DM_Ack = 1'($urandom_range(0, 1));
        DM_RData = $urandom;
      end
    end

    // Reset in the middle of an access, then a clean load
    @(negedge CLK);
    DM_Ack = 0;
    exp_q.push_back(model(1, 0, 3'b010, 32'h0000_8000, 0, 0, TMO + 5, model_ld));
    MEM_Read = 1; MEM_Write = 0; Funct3 = 3'b010; ALU_Output = 32'h0000_8000;
    guard = 0;
    do begin
      @(negedge CLK);
      guard++;
    end while (!DM_Req && guard < 10);
    chk("mid_access_req", 32'(DM_Req), 32'h1);
    RSTN = 0; MEM_Read = 0;
    #1;
    exp_q.delete();
    model_ld = 32'h0;
    chk("arst_req", 32'(DM_Req), 0);
    chk("arst_stall", 32'(Stall), 0);
    chk("arst_ld", Load_Data, 0);
    chk("arst_be", 32'(DM_BE), 0);
    @(negedge CLK);
    RSTN = 1;
    run_txn(1, 0, 3'b010, 32'h0000_9008, 0, 32'h1357_9BDF, 2);

    repeat (3) @(negedge CLK);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
